// File: rtl/forward_scoreboard_if.sv
// EX-stage operand/destination bus into the forwarding scoreboard and its
// per-source forward selects, stall request and stall statistics back out.
interface forward_scoreboard_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic                      ex_valid;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_wr_en;
    logic                      ex_is_load;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic                      flush;
    logic                      hold;
    logic [NUM_SRC*3-1:0]      fwd_sel;
    logic                      stall;
    logic [15:0]               stall_count;

    modport master (
        output ex_valid, ex_rd, ex_wr_en, ex_is_load, ex_rs, flush, hold,
        input  fwd_sel, stall, stall_count
    );

    modport slave (
        input  ex_valid, ex_rd, ex_wr_en, ex_is_load, ex_rs, flush, hold,
        output fwd_sel, stall, stall_count
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Tracks destinations of the DEPTH stages after EX, picks per-source bypass
// stages and requests a stall when the youngest producer is a load not yet ready.
module forward_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    forward_scoreboard_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } entry_t;

    entry_t             ent [DEPTH:1];
    logic [NUM_SRC-1:0] src_unavail;
    logic [15:0]        stall_cnt_q;
    logic               stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic [2:0]        sel;
        logic              unavail;
        logic              found;

        assign rs = bus.ex_rs[i*REG_AW +: REG_AW];

        // Only the youngest match counts; an older ready copy is stale data.
        always_comb begin
            found   = 1'b0;
            sel     = 3'd0;
            unavail = 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && ent[k].valid && ent[k].rd == rs && rs != '0) begin
                    found = 1'b1;
                    if (!ent[k].is_load || k > LOAD_LAT)
                        sel = 3'(k);
                    else
                        unavail = 1'b1;
                end
            end
        end

        assign bus.fwd_sel[i*3 +: 3] = sel;
        assign src_unavail[i]        = unavail;
    end

    assign stall           = bus.ex_valid & (|src_unavail);
    assign bus.stall       = stall;
    assign bus.stall_count = stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 1; s <= DEPTH; s++)
                ent[s] <= '0;
            stall_cnt_q <= '0;
        end else if (!bus.hold) begin
            for (int s = DEPTH; s >= 2; s--)
                ent[s] <= ent[s-1];
            // Flush wins over stall: both leave a bubble behind.
            if (bus.ex_valid && !stall && !bus.flush)
                ent[1] <= '{valid: bus.ex_wr_en, rd: bus.ex_rd, is_load: bus.ex_is_load};
            else
                ent[1] <= '0;
            if (stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench: each vector queues its expected outputs; a negedge monitor
// pops and compares fwd_sel/stall/stall_count for every driven cycle.
module tb_forward_scoreboard;
    logic clk;
    logic reset_n;

    forward_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) bus ();

    forward_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  fwd;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.fwd_sel !== e.fwd || bus.stall !== e.stall || bus.stall_count !== e.cnt) begin
                n_bad++;
                $display("FAIL %s: got fwd_sel=%b stall=%b cnt=%0d, want fwd_sel=%b stall=%b cnt=%0d",
                         e.name, bus.fwd_sel, bus.stall, bus.stall_count, e.fwd, e.stall, e.cnt);
            end
        end
    end

    // One cycle of stimulus; expected values are the combinational outputs
    // for this cycle, given everything retired on earlier edges.
    task automatic step(input string nm, input logic rn, input logic v, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic [4:0] r0, input logic [4:0] r1,
                        input logic fl, input logic hd,
                        input logic [5:0] ef, input logic es, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n        = rn;
        bus.ex_valid   = v;
        bus.ex_rd      = rd;
        bus.ex_wr_en   = wr;
        bus.ex_is_load = ld;
        bus.ex_rs      = {r1, r0};
        bus.flush      = fl;
        bus.hold       = hd;
        e.name = nm; e.fwd = ef; e.stall = es; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_wr_en = 0; bus.ex_is_load = 0;
        bus.ex_rs = 0; bus.flush = 0; bus.hold = 0;

        //    name           rn v  rd wr ld r0  r1 fl hd  fwd        st cnt
        step("reset",        0, 0, 0, 0, 0, 0,  0, 0, 0, 6'b000000, 0, 0);
        step("add_x5",       1, 1, 5, 1, 0, 1,  2, 0, 0, 6'b000000, 0, 0);
        step("use_x5_e1",    1, 1, 6, 1, 0, 5,  3, 0, 0, 6'b000001, 0, 0);
        step("use_x5_e2",    1, 1, 8, 1, 0, 5,  6, 0, 0, 6'b001010, 0, 0);
        step("wr_x7_a",      1, 1, 7, 1, 0, 0,  0, 0, 0, 6'b000000, 0, 0);
        step("wr_x10",       1, 1, 10,1, 0, 0,  0, 0, 0, 6'b000000, 0, 0);
        step("wr_x7_b",      1, 1, 7, 1, 0, 0,  7, 0, 0, 6'b010000, 0, 0);
        step("youngest_x7",  1, 1, 11,0, 0, 10, 7, 0, 0, 6'b001010, 0, 0);
        step("wr_x0",        1, 1, 0, 1, 0, 7,  0, 0, 0, 6'b000010, 0, 0);
        step("use_x0",       1, 1, 0, 0, 0, 0,  11,0, 0, 6'b000000, 0, 0);
        step("ld_x9",        1, 1, 9, 1, 1, 0,  0, 0, 0, 6'b000000, 0, 0);
        step("ldu_stall",    1, 1, 12,1, 0, 9,  0, 0, 0, 6'b000000, 1, 0);
        step("ldu_release",  1, 1, 12,1, 0, 9,  0, 0, 0, 6'b000010, 0, 1);
        step("ld_x13",       1, 1, 13,1, 1, 0,  0, 0, 0, 6'b000000, 0, 1);
        step("flush_stall",  1, 1, 14,1, 0, 13, 12,1, 0, 6'b010000, 1, 1);
        step("after_flush",  1, 1, 15,1, 0, 13, 14,0, 0, 6'b000010, 0, 2);
        step("ld_x16",       1, 1, 16,1, 1, 0,  15,0, 0, 6'b001000, 0, 2);
        step("hold_1",       1, 1, 17,1, 0, 16, 0, 0, 1, 6'b000000, 1, 2);
        step("hold_2",       1, 1, 17,1, 0, 16, 0, 0, 1, 6'b000000, 1, 2);
        step("hold_3",       1, 1, 17,1, 0, 16, 0, 0, 1, 6'b000000, 1, 2);
        step("unhold_stall", 1, 1, 17,1, 0, 16, 0, 0, 0, 6'b000000, 1, 2);
        step("unhold_fwd",   1, 1, 17,1, 0, 16, 0, 0, 0, 6'b000010, 0, 3);
        step("ld_x18",       1, 1, 18,1, 1, 0,  0, 0, 0, 6'b000000, 0, 3);
        step("hold_ldu",     1, 1, 19,1, 0, 18, 17,0, 1, 6'b010000, 1, 3);
        step("mid_reset",    0, 1, 19,1, 0, 18, 17,0, 1, 6'b000000, 0, 0);
        step("post_reset",   1, 1, 19,1, 0, 18, 17,0, 0, 6'b000000, 0, 0);
        step("post_rst_fwd", 1, 1, 0, 0, 0, 19, 18,0, 0, 6'b000001, 0, 0);
        step("ld_x20",       1, 1, 20,1, 1, 19, 0, 0, 0, 6'b000010, 0, 0);
        step("invalid_ex",   1, 0, 0, 0, 0, 20, 19,0, 0, 6'b011000, 0, 0);
        step("use_x20",      1, 1, 0, 0, 0, 20, 0, 0, 0, 6'b000010, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning the register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning the number of source operands checked per instruction.
REQ-003 SHALL have parameter DEPTH, default 3, meaning the number of post-EX pipeline stages tracked (range 2..7).
REQ-004 SHALL have parameter LOAD_LAT, default 1, meaning the stages after EX before load data is forwardable (range 0..DEPTH-1).
REQ-005 SHALL define port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL define port: reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL define port: ex_valid  input  1  instruction present in EX.
REQ-008 SHALL define port: ex_rd  input  REG_AW  EX destination register.
REQ-009 SHALL define port: ex_wr_en  input  1  EX instruction writes rd.
REQ-010 SHALL define port: ex_is_load  input  1  EX instruction is a load.
REQ-011 SHALL define port: ex_rs  input  NUM_SRC*REG_AW  EX source registers, source i at bits [i*REG_AW +: REG_AW].
REQ-012 SHALL define port: flush  input  1  kill the EX instruction.
REQ-013 SHALL define port: hold  input  1  external freeze of the whole pipeline.
REQ-014 SHALL define port: fwd_sel  output  NUM_SRC*3  per-source select, 0 = register file, k = forward from tracked stage k.
REQ-015 SHALL define port: stall  output  1  load-use stall request.
REQ-016 SHALL define port: stall_count  output  16  saturating count of stall cycles.

Function
REQ-017 SHALL hold DEPTH tracker entries {valid, rd, is_load}; entry 1 is the stage immediately after EX, entry DEPTH is the oldest.
REQ-018 SHALL treat an entry as matching source i when the entry is valid, entry rd == ex_rs[i], and entry rd != 0; x0 never forwards and never stalls.
REQ-019 SHALL select, per source, only the lowest-numbered (youngest) matching entry; older matches are ignored.
REQ-020 SHALL treat the youngest match as available when is_load==0, or when is_load==1 and entry index > LOAD_LAT.
REQ-021 SHALL drive fwd_sel[i] to the index of the youngest match when it is available, else 0; fwd_sel is combinational and zero-latency.
REQ-022 SHALL assert stall when ex_valid==1 and any source's youngest match is unavailable; an available older match does not suppress the stall.
REQ-023 SHALL, on a rising edge with hold==1, keep all entries and stall_count unchanged.
REQ-024 SHALL, on a rising edge with hold==0, shift entry[s] <= entry[s-1] for s = 2..DEPTH and discard the old entry[DEPTH].
REQ-025 SHALL, on a rising edge with hold==0, load entry 1 with {ex_valid & ex_wr_en, ex_rd, ex_is_load} when ex_valid==1, stall==0 and flush==0.
REQ-026 SHALL, on a rising edge with hold==0 otherwise, load entry 1 with a bubble (valid=0).
REQ-027 SHALL give flush priority over stall: with both asserted, a bubble is inserted and older entries still shift.
REQ-028 SHALL increment stall_count by 1 on each edge where stall==1 and hold==0, saturating at 16'hFFFF.
REQ-029 SHALL let a stalled instruction re-evaluate each cycle, so stall deasserts automatically once the load reaches index LOAD_LAT+1.
REQ-030 SHALL, when LOAD_LAT==0, never assert stall.
REQ-031 SHALL set stall==0 whenever ex_valid==0, regardless of ex_rs.

Reset
REQ-032 SHALL, while reset_n==0, asynchronously clear every entry valid bit, rd and is_load to 0, and clear stall_count to 0.
REQ-033 SHALL drive fwd_sel to all zeros and stall to 0 during reset, since no entry is valid.
REQ-034 SHALL, when reset is asserted mid-operation, discard all in-flight entries; the first post-reset instruction sees no forwarding.

Verification
REQ-035 SHALL cover back-to-back ALU ops: add x5 then a use of x5 as rs1 -> fwd_sel[0]=1, stall=0; the next cycle an unrelated op then a use of x5 -> fwd_sel[0]=2.
REQ-036 SHALL cover youngest-wins: x7 written in entries 1 and 3 with rs2=x7 -> fwd_sel[1]=1.
REQ-037 SHALL cover load-use with LOAD_LAT=1: a load to x9 with the next instruction using x9 -> stall=1 for exactly 1 cycle, then fwd_sel=2 and stall_count=1.
REQ-038 SHALL cover the x0 case: the previous instruction writes x0 and rs1=x0 -> fwd_sel[0]=0, stall=0.
REQ-039 SHALL cover flush together with stall: the bubble is inserted, the load advances to entry 2, and the flushed instruction leaves no entry.
REQ-040 SHALL cover hold for 3 cycles during a load-use: entries are frozen, stall stays 1, stall_count is unchanged; reset_n pulsed low mid-sequence -> all outputs 0 immediately.
